// File: rtl/snn_pkg.sv
// Shared definitions for the SNN tick scheduler: state encoding and state helpers.
package snn_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    TS_IDLE      = 3'd0,
    TS_LOAD      = 3'd1,
    TS_TICK      = 3'd2,
    TS_SETTLE    = 3'd3,
    TS_WAIT_STEP = 3'd4,
    TS_DONE      = 3'd5,
    TS_ERROR     = 3'd6
  } tick_state_e;

  function automatic logic is_active(tick_state_e s);
    return !(s inside {TS_IDLE, TS_DONE, TS_ERROR});
  endfunction

endpackage

// File: rtl/snn_watchdog.sv
// Drain watchdog: counts enabled cycles and flags the cycle whose count completes 2^TIMEOUT_W-1.
module snn_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // One below all-ones: expired fires in the cycle whose increment reaches all-ones.
  localparam logic [TIMEOUT_W-1:0] LAST = ~TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/snn_tick_scheduler.sv
// Tick sequencer for an N-core SNN grid: budgeted ticks, single-step, drain supervision, abort.
module snn_tick_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_CORES  = 6,
  parameter int TICK_W     = 16,
  parameter int MIN_SETTLE = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 load_end,
  input  logic                 step_mode,
  input  logic                 step_req,
  input  logic [TICK_W-1:0]    cfg_num_ticks,
  input  logic                 input_buffer_empty,
  input  logic                 router_empty_all,
  input  logic [NUM_CORES-1:0] core_busy,
  output logic                 tick,
  output logic [TICK_W-1:0]    tick_index,
  output logic                 complete,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [STATE_W-1:0]   state
);

  localparam int SETTLE_W = (MIN_SETTLE > 1) ? $clog2(MIN_SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(MIN_SETTLE - 1);

  tick_state_e         state_q;
  logic [TICK_W-1:0]   budget;
  logic                step_latched;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                wd_enable;
  logic                wd_expired;
  logic                drained;
  logic                load_ready;

  assign drained    = input_buffer_empty && router_empty_all && ~|core_busy;
  assign load_ready = load_end && input_buffer_empty && router_empty_all;
  assign wd_enable  = (state_q == TS_LOAD) || (state_q == TS_SETTLE);

  snn_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~wd_enable),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TS_IDLE;
      tick         <= 1'b0;
      tick_index   <= '0;
      complete     <= 1'b0;
      timeout_err  <= 1'b0;
      budget       <= '0;
      step_latched <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      tick <= 1'b0;
      if (abort) begin
        state_q  <= TS_IDLE;
        complete <= 1'b0;
      end else begin
        unique case (state_q)
          TS_IDLE, TS_DONE, TS_ERROR: begin
            if (start) begin
              budget       <= cfg_num_ticks;
              step_latched <= step_mode;
              tick_index   <= '0;
              timeout_err  <= 1'b0;
              complete     <= (cfg_num_ticks == '0);
              state_q      <= (cfg_num_ticks == '0) ? TS_DONE : TS_LOAD;
            end
          end
          TS_LOAD: begin
            if (wd_expired) begin
              state_q     <= TS_ERROR;
              timeout_err <= 1'b1;
              complete    <= 1'b0;
            end else if (load_ready) begin
              state_q    <= TS_TICK;
              tick       <= 1'b1;
              tick_index <= tick_index + TICK_W'(1);
            end
          end
          TS_TICK: begin
            state_q    <= TS_SETTLE;
            settle_cnt <= '0;
          end
          TS_SETTLE: begin
            if (wd_expired) begin
              state_q     <= TS_ERROR;
              timeout_err <= 1'b1;
              complete    <= 1'b0;
            end else if (settle_cnt != SETTLE_LAST) begin
              settle_cnt <= settle_cnt + SETTLE_W'(1);
            end else if (drained) begin
              // The settle counter parks at its last value, so drain is re-tested every cycle.
              if (tick_index == budget) begin
                state_q  <= TS_DONE;
                complete <= 1'b1;
              end else if (step_latched) begin
                state_q <= TS_WAIT_STEP;
              end else begin
                state_q    <= TS_TICK;
                tick       <= 1'b1;
                tick_index <= tick_index + TICK_W'(1);
              end
            end
          end
          TS_WAIT_STEP: begin
            if (step_req) begin
              state_q    <= TS_TICK;
              tick       <= 1'b1;
              tick_index <= tick_index + TICK_W'(1);
            end
          end
          default: state_q <= TS_IDLE;
        endcase
      end
    end
  end

  assign busy  = is_active(state_q);
  assign state = state_q;

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// Self-checking bench for snn_tick_scheduler: cycle model plus directed literal checks.
module tb_snn_tick_scheduler;

  localparam int NUM_CORES  = 6;
  localparam int TICK_W     = 16;
  localparam int MIN_SETTLE = 4;
  localparam int TIMEOUT_W  = 6;
  localparam int WD_LIMIT   = (1 << TIMEOUT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 load_end = 1'b0;
  logic                 step_mode = 1'b0;
  logic                 step_req = 1'b0;
  logic [TICK_W-1:0]    cfg_num_ticks = '0;
  logic                 input_buffer_empty = 1'b1;
  logic                 router_empty_all = 1'b1;
  logic [NUM_CORES-1:0] core_busy = '0;
  logic                 tick;
  logic [TICK_W-1:0]    tick_index;
  logic                 complete;
  logic                 timeout_err;
  logic                 busy;
  logic [2:0]           state;

  snn_tick_scheduler #(
    .NUM_CORES (NUM_CORES),
    .TICK_W    (TICK_W),
    .MIN_SETTLE(MIN_SETTLE),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .load_end          (load_end),
    .step_mode         (step_mode),
    .step_req          (step_req),
    .cfg_num_ticks     (cfg_num_ticks),
    .input_buffer_empty(input_buffer_empty),
    .router_empty_all  (router_empty_all),
    .core_busy         (core_busy),
    .tick              (tick),
    .tick_index        (tick_index),
    .complete          (complete),
    .timeout_err       (timeout_err),
    .busy              (busy),
    .state             (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_times[$];
  int busy_len = 2;
  int busy_left = 0;
  logic [NUM_CORES-1:0] stuck_mask = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Cores stay busy for busy_len cycles starting with the tick cycle.
  always @(posedge clk) begin
    #1;
    if (tick === 1'b1) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
    core_busy = (busy_left > 0) ? '1 : stuck_mask;
  end

  always @(negedge clk) if (tick === 1'b1) tick_times.push_back(cyc);

  // Reference model: run phase, ticks issued, cycles since last tick, supervised-cycle count.
  int              m_phase = 0;
  logic            m_tick = 1'b0;
  logic [TICK_W-1:0] m_index = '0;
  logic [TICK_W-1:0] m_budget = '0;
  logic            m_complete = 1'b0;
  logic            m_terr = 1'b0;
  logic            m_step = 1'b0;
  int              m_since = 0;
  int              m_wd = 0;

  always @(posedge clk) begin
    int  nxt;
    bit  drained;
    drained = input_buffer_empty && router_empty_all && (core_busy == '0);
    nxt = m_phase;
    if (reset) begin
      nxt = 0; m_tick = 0; m_index = '0; m_budget = '0; m_complete = 0;
      m_terr = 0; m_step = 0; m_since = 0; m_wd = 0;
    end else begin
      m_tick = 0;
      if (abort) begin
        nxt = 0; m_complete = 0;
      end else if (m_phase == 0 || m_phase == 5 || m_phase == 6) begin
        if (start) begin
          m_budget = cfg_num_ticks; m_step = step_mode; m_index = '0; m_terr = 0; m_wd = 0;
          m_complete = (cfg_num_ticks == '0);
          nxt = (cfg_num_ticks == '0) ? 5 : 1;
        end
      end else if (m_phase == 1) begin
        m_wd++;
        if (m_wd == WD_LIMIT) begin nxt = 6; m_terr = 1; m_complete = 0; end
        else if (load_end && input_buffer_empty && router_empty_all) begin
          nxt = 2; m_tick = 1; m_index++;
        end
      end else if (m_phase == 2) begin
        nxt = 3; m_since = 0; m_wd = 0;
      end else if (m_phase == 3) begin
        m_since++; m_wd++;
        if (m_wd == WD_LIMIT) begin nxt = 6; m_terr = 1; m_complete = 0; end
        else if (m_since >= MIN_SETTLE && drained) begin
          if (m_index == m_budget) begin nxt = 5; m_complete = 1; end
          else if (m_step) nxt = 4;
          else begin nxt = 2; m_tick = 1; m_index++; end
        end
      end else if (m_phase == 4) begin
        if (step_req) begin nxt = 2; m_tick = 1; m_index++; end
      end
    end
    m_phase = nxt;
  end

  always @(negedge clk) begin
    check("tick", 32'(tick), 32'(m_tick));
    check("tick_index", 32'(tick_index), 32'(m_index));
    check("complete", 32'(complete), 32'(m_complete));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("state", 32'(state), 32'(m_phase));
    check("busy", 32'(busy), 32'(!(m_phase == 0 || m_phase == 5 || m_phase == 6)));
  end

  task automatic pulse_start(input logic [TICK_W-1:0] n, input logic smode);
    @(posedge clk); #2 start = 1'b1; cfg_num_ticks = n; step_mode = smode;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int max_cyc, input string name);
    int n = 0;
    @(negedge clk);
    while (state !== exp && n < max_cyc) begin @(negedge clk); n++; end
    check(name, 32'(state), 32'(exp));
  endtask

  // Returns at the negedge of the cycle carrying tick number idx.
  task automatic wait_tick(input int idx, input int max_cyc, input string name);
    int n = 0;
    @(negedge clk);
    while (!(tick === 1'b1 && tick_index == TICK_W'(idx)) && n < max_cyc) begin
      @(negedge clk); n++;
    end
    check(name, 32'(tick_index), 32'(idx));
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_index", 32'(tick_index), 0);
    check("rst_complete", 32'(complete), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk); #2 reset = 1'b0;

    // abort wins over start in IDLE
    @(posedge clk); #2 start = 1'b1; abort = 1'b1; cfg_num_ticks = 16'd3;
    @(posedge clk); #2 start = 1'b0; abort = 1'b0;
    @(negedge clk); check("abort_over_start", 32'(state), 0);

    // Budget 3, free run, cores busy 2 cycles after each tick
    tick_times.delete();
    pulse_start(16'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("load_hold", 32'(state), 1);
    load_end = 1'b1;
    wait_state(3'd5, 100, "a_done");
    check("a_ticks", 32'(tick_times.size()), 3);
    if (tick_times.size() == 3) begin
      check("a_gap1", 32'(tick_times[1] - tick_times[0]), 5);
      check("a_gap2", 32'(tick_times[2] - tick_times[1]), 5);
    end
    check("a_index", 32'(tick_index), 3);
    check("a_complete", 32'(complete), 1);

    // Longer busy window stretches spacing to busy_len+1
    busy_len = 7;
    tick_times.delete();
    pulse_start(16'd2, 1'b0);
    wait_state(3'd5, 100, "a2_done");
    check("a2_ticks", 32'(tick_times.size()), 2);
    if (tick_times.size() == 2) check("a2_gap", 32'(tick_times[1] - tick_times[0]), 8);
    busy_len = 2;

    // Step mode, budget 2
    tick_times.delete();
    pulse_start(16'd2, 1'b1);
    wait_tick(1, 50, "b_tick1");
    @(posedge clk); #2 step_req = 1'b1;
    @(posedge clk); #2 step_req = 1'b0;
    wait_state(3'd4, 50, "b_wait_step");
    repeat (3) @(negedge clk);
    check("b_still_wait", 32'(state), 4);
    check("b_index1", 32'(tick_index), 1);
    @(posedge clk); #2 step_req = 1'b1;
    @(posedge clk); #2 step_req = 1'b0;
    @(negedge clk);
    check("b_tick2", 32'(tick), 1);
    check("b_index2", 32'(tick_index), 2);
    wait_state(3'd5, 50, "b_done");
    check("b_ticks", 32'(tick_times.size()), 2);

    // Budget 0 relaunch from DONE: straight to DONE, index cleared, no tick
    tick_times.delete();
    pulse_start(16'd0, 1'b0);
    @(negedge clk);
    check("c_state", 32'(state), 5);
    check("c_complete", 32'(complete), 1);
    check("c_index", 32'(tick_index), 0);
    repeat (3) @(negedge clk);
    check("c_no_tick", 32'(tick_times.size()), 0);

    // Stuck core -> watchdog error 63 cycles into SETTLE
    stuck_mask = 6'b100000;
    pulse_start(16'd2, 1'b0);
    wait_tick(1, 50, "d_tick1");
    t0 = cyc;
    wait_state(3'd6, 200, "d_error");
    check("d_latency", 32'(cyc - t0), 64);
    check("d_terr", 32'(timeout_err), 1);
    check("d_complete", 32'(complete), 0);
    stuck_mask = '0;
    pulse_start(16'd1, 1'b0);
    @(negedge clk);
    check("d_terr_clr", 32'(timeout_err), 0);
    check("d_relaunch", 32'(state), 1);
    wait_state(3'd5, 50, "d_done");

    // Abort coincident with drain test in SETTLE
    pulse_start(16'd5, 1'b0);
    wait_tick(1, 50, "e_tick1");
    repeat (4) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    check("e_state", 32'(state), 0);
    check("e_tick", 32'(tick), 0);
    check("e_index", 32'(tick_index), 1);
    check("e_complete", 32'(complete), 0);

    // Reset mid-SETTLE
    pulse_start(16'd5, 1'b0);
    wait_tick(2, 50, "f_tick2");
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("f_state", 32'(state), 0);
    check("f_index", 32'(tick_index), 0);
    check("f_busy", 32'(busy), 0);
    check("f_terr", 32'(timeout_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
